// File: rtl/fifo_ctrl.sv
// Pointer and status controller for a synchronous FIFO of depth 2**W built
// around an external dual-address register file.
module fifo_ctrl #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr_err,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         push_ok, pop_ok;

  // A push into a full FIFO is still accepted when a pop frees the slot at
  // the same edge; the register file returns the pre-edge word to the reader.
  always_comb begin
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;

    w_ptr_d = push_ok ? w_ptr_q + W'(1) : w_ptr_q;
    r_ptr_d = pop_ok  ? r_ptr_q + W'(1) : r_ptr_q;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (W+1)'(1);
      2'b01:   count_d = count_q - (W+1)'(1);
      default: count_d = count_q;
    endcase

    // Flags follow the occupancy, equivalent to the pointer-equality rules.
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);

    // Set wins over clear when a rejection coincides with clr_err.
    ovf_d = (ovf_q & ~clr_err) | (wr & ~push_ok);
    unf_d = (unf_q & ~clr_err) | (rd & ~pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign wr_en     = push_ok;
  assign w_addr    = w_ptr_q;
  assign r_addr    = r_ptr_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller for a synchronous FIFO. It drives the write enable and both addresses of the dual-address register file, and the two together form a FIFO of depth 2**W. Upstream producers assert `wr` with data routed straight to the register file's write-data port. Downstream consumers take the head word from the register file's read data whenever `empty` is low, and assert `rd` to pop it.

## Interface
- `W`, default 2: address width. FIFO depth = 2**W entries.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr`  in  1  push request; the push data is presented to the register file in the same cycle.
- `rd`  in  1  pop request; the head word is consumed at this edge.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `wr_en`  out  1  write strobe to the register file (combinational).
- `w_addr`  out  W  write address to the register file (registered write pointer).
- `r_addr`  out  W  read address to the register file (registered read pointer).
- `full`  out  1  FIFO holds 2**W entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  W+1  current occupancy, 0..2**W.
- `overflow`  out  1  sticky flag: a push was rejected.
- `underflow`  out  1  sticky flag: a pop was rejected.

## Operation
- Reset (`reset_n`=0, asynchronous) drives the state as follows, and it holds until the first edge after release:
  - w_ptr=0, r_ptr=0, count=0.
  - full=0, empty=1.
  - overflow=0, underflow=0.
- Accept terms (combinational):
  - push_ok = wr & (~full | rd)
  - pop_ok = rd & ~empty
  - wr_en = push_ok
- Pointer update:
  - On push_ok, w_ptr <= w_ptr+1, modulo 2**W; wrap-around is natural.
  - On pop_ok, r_ptr <= r_ptr+1, modulo 2**W.
- Count update:
  - push_ok only: count+1.
  - pop_ok only: count-1.
  - Both or neither: count is unchanged.
- Status update, by {wr,rd}:
  - 00: no change.
  - 10, not full: push. empty<=0; full<=1 if (w_ptr+1)==r_ptr.
  - 10, full: rejected. overflow<=1; the register file is not written.
  - 01, not empty: pop. full<=0; empty<=1 if (r_ptr+1)==w_ptr.
  - 01, empty: rejected. underflow<=1; pointers are held.
  - 11, empty: push only; the pop is rejected and underflow<=1. empty<=0; full<=1 only when W=0 (not supported, W>=1).
  - 11, full: both accepted. The write lands at the slot being read (w_ptr==r_ptr); the popped word is the pre-edge value. full stays 1, and no overflow is raised.
  - 11, otherwise: both accepted. Flags are unchanged.
- Error flags: clr_err=1 clears overflow and underflow at the edge. If a rejection occurs in the same cycle as clr_err, the flag is set (set wins).
- Invariants:
  - full & empty is never 1.
  - full == (count==2**W).
  - empty == (count==0).

## Timing
- All outputs except wr_en are registered; they change only on the rising clk edge or on reset assertion.
- wr_en is combinational from wr, rd and full, with zero latency.
- Push latency: data written at edge N is readable via r_addr from edge N if the FIFO was empty. empty falls after edge N, so the consumer sees the word one cycle after the push cycle.
- Pop: the word at r_addr is valid throughout any cycle with empty=0. The pointer advances at the edge that samples rd=1.
- Full/empty deassert in the same edge as the opposing operation; there is no extra pipeline stage.
- Reset mid-operation: all state returns immediately to reset values. Register-file contents are not cleared and are simply treated as invalid.

## Test plan
- Reset then idle:
  - Stimulus: reset_n pulsed low mid-cycle, wr=rd=0.
  - Required: empty=1, full=0, count=0, w_addr=r_addr=0, and no wr_en. The reset must take effect without a clock edge.
- Fill to full, W=2:
  - Stimulus: 4 consecutive pushes of 0xA1..0xA4.
  - Required: after the 4th edge full=1, count=4, w_addr=0. A 5th push gives wr_en=0, sets overflow=1, and leaves count=4.
- Drain with wrap:
  - Stimulus: from full, 4 pops.
  - Required: the data seen at r_addr is 0xA1..0xA4 in order. After the last pop empty=1 and r_addr=0. A 5th pop sets underflow=1 and leaves r_addr=0.
- Simultaneous push/pop while full:
  - Stimulus: wr=rd=1 for 3 cycles.
  - Required: count stays 4, full stays 1, both pointers advance by 3 (mod 4), and no overflow is raised. Popped words are the oldest entries in order.
- Simultaneous push/pop while empty:
  - Stimulus: wr=rd=1 with data 0x5C.
  - Required: count becomes 1, empty=0, underflow=1, r_addr is unchanged, and the next pop returns 0x5C.
- Error clear:
  - Stimulus: with overflow=1, assert clr_err alone.
  - Required: overflow=0 after the edge.
  - Stimulus: then assert clr_err together with a push while full.
  - Required: overflow=1 (set wins).
